// File: rtl/harmonic_synth_engine_if.sv
// Bus between the note player / voice mixer / sine ROM and the harmonic
// synthesis engine.
//   slave  : engine side (takes requests and ROM data, drives the ROM
//            address and the summed sample)
//   master : environment side (note player, ROM, mixer)
// Signals: play_enable, generate_next_sample, note_done, note_start,
//          step_size, gains (packed, harmonic k in [k*GAIN_W-1 -: GAIN_W]),
//          rom_addr, rom_data, harmonic_out, sample_ready, busy.
interface harmonic_synth_engine_if #(
  parameter int NUM_HARM = 4,
  parameter int STEP_W   = 20,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 4,
  parameter int ADDR_W   = 10
);
  logic                         play_enable;
  logic                         generate_next_sample;
  logic                         note_done;
  logic                         note_start;
  logic [STEP_W-1:0]            step_size;
  logic [NUM_HARM*GAIN_W-1:0]   gains;
  logic [ADDR_W-1:0]            rom_addr;
  logic signed [SAMPLE_W-1:0]   rom_data;
  logic signed [SAMPLE_W-1:0]   harmonic_out;
  logic                         sample_ready;
  logic                         busy;

  modport master (
    output play_enable, generate_next_sample, note_done, note_start,
    output step_size, gains, rom_data,
    input  rom_addr, harmonic_out, sample_ready, busy
  );

  modport slave (
    input  play_enable, generate_next_sample, note_done, note_start,
    input  step_size, gains, rom_data,
    output rom_addr, harmonic_out, sample_ready, busy
  );
endinterface

// File: rtl/harmonic_synth_engine.sv
// Additive-harmonic voice generator. NUM_HARM harmonics of a base note are
// evaluated one after another through a single shared sine ROM port, each
// scaled by its own unsigned gain (g / 2^GAIN_W), summed, and saturated to
// one signed SAMPLE_W output per request.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : harmonic_synth_engine_if.slave (request/ROM/output signals)
// Each harmonic takes an ADDR cycle (present the ROM address, advance the
// phase) followed by a MAC cycle (ROM data arrives, multiply-accumulate),
// then one OUT cycle publishes the result.
module harmonic_synth_engine #(
  parameter int NUM_HARM = 4,
  parameter int STEP_W   = 20,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 4,
  parameter int ADDR_W   = 10
) (
  input logic                   clk,
  input logic                   reset,
  harmonic_synth_engine_if.slave bus
);

  localparam int HIDX_W = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_HARM) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, MAC, OUT} state_t;

  state_t                     state, state_nxt;
  logic [STEP_W-1:0]          phase [NUM_HARM];
  logic [STEP_W-1:0]          step_lat;
  logic [STEP_W-1:0]          hstep;
  logic [NUM_HARM*GAIN_W-1:0] gains_lat;
  logic [HIDX_W-1:0]          hidx;       // 0-based: hidx 0 is harmonic 1
  logic signed [ACC_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] harm_out;
  logic [ADDR_W-1:0]          rom_addr_q;

  logic                       trigger;
  logic                       last_harm;
  logic [GAIN_W-1:0]          gain_arr [NUM_HARM];
  logic [GAIN_W-1:0]          gain_cur;
  logic [ADDR_W-1:0]          cur_addr;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_shift;
  logic                       busy_c;
  logic                       ready_c;

  // Clamp a scaled accumulator value into the signed output range. The value
  // fits when every bit from the output sign bit upward is identical.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(
    input logic signed [ACC_W-1:0] v
  );
    if ((&v[ACC_W-1:SAMPLE_W-1]) || (~|v[ACC_W-1:SAMPLE_W-1]))
      return v[SAMPLE_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(SAMPLE_W-1){1'b0}}};
    else
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction

  assign trigger   = bus.generate_next_sample && bus.play_enable &&
                     !bus.note_done && (state == IDLE);
  assign last_harm = (hidx == HIDX_W'(NUM_HARM - 1));

  always_comb begin
    for (int i = 0; i < NUM_HARM; i++)
      gain_arr[i] = gains_lat[i*GAIN_W +: GAIN_W];
  end

  assign gain_cur  = gain_arr[hidx];
  assign cur_addr  = phase[hidx][STEP_W-1 -: ADDR_W];
  // Gain is unsigned: a zero sign bit keeps it non-negative in the product.
  assign prod      = PROD_W'(bus.rom_data) * PROD_W'($signed({1'b0, gain_cur}));
  assign prod_ext  = ACC_W'(prod);
  assign acc_shift = acc >>> GAIN_W;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; note_start overrides every state and any trigger.
  always_comb begin
    state_nxt = state;
    if (bus.note_start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (trigger) state_nxt = ADDR;
        ADDR:    state_nxt = MAC;
        MAC:     state_nxt = last_harm ? OUT : ADDR;
        OUT:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; an aborted OUT cycle must not pulse ready.
  always_comb begin
    busy_c  = (state != IDLE);
    ready_c = (state == OUT) && !bus.note_start;
  end

  // Phase / accumulator datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_HARM; i++) phase[i] <= '0;
      step_lat   <= '0;
      hstep      <= '0;
      gains_lat  <= '0;
      hidx       <= '0;
      acc        <= '0;
      harm_out   <= '0;
      rom_addr_q <= '0;
    end else if (bus.note_start) begin
      for (int i = 0; i < NUM_HARM; i++) phase[i] <= '0;
      hstep <= '0;
      hidx  <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            step_lat  <= bus.step_size;
            gains_lat <= bus.gains;
            hstep     <= bus.step_size;
            acc       <= '0;
            hidx      <= '0;
          end
        end
        ADDR: begin
          rom_addr_q  <= cur_addr;
          phase[hidx] <= phase[hidx] + hstep;
        end
        MAC: begin
          acc   <= acc + prod_ext;
          // Running sum gives harmonic k a step of k*step_size (mod 2^STEP_W).
          hstep <= hstep + step_lat;
          if (!last_harm) hidx <= hidx + 1'b1;
        end
        OUT: begin
          harm_out <= sat_sample(acc_shift);
        end
        default: ;
      endcase
    end
  end

  // Address is live from the phase register while in ADDR, held otherwise.
  assign bus.rom_addr     = (state == ADDR) ? cur_addr : rom_addr_q;
  assign bus.harmonic_out = harm_out;
  assign bus.sample_ready = ready_c;
  assign bus.busy         = busy_c;

endmodule

// File: tb/tb_harmonic_synth_engine.sv
module tb_harmonic_synth_engine;
  localparam int NH       = 4;
  localparam int STEP_W   = 20;
  localparam int SAMPLE_W = 16;
  localparam int GAIN_W   = 4;
  localparam int ADDR_W   = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  harmonic_synth_engine_if #(.NUM_HARM(NH), .STEP_W(STEP_W), .SAMPLE_W(SAMPLE_W),
                             .GAIN_W(GAIN_W), .ADDR_W(ADDR_W)) bus ();

  harmonic_synth_engine #(.NUM_HARM(NH), .STEP_W(STEP_W), .SAMPLE_W(SAMPLE_W),
                          .GAIN_W(GAIN_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Sine ROM model: either a constant or a random table, one-cycle latency.
  logic signed [SAMPLE_W-1:0] rom_tab [1 << ADDR_W];
  bit                         rom_const_mode;
  logic signed [SAMPLE_W-1:0] rom_const;

  function automatic logic signed [SAMPLE_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    return rom_const_mode ? rom_const : rom_tab[a];
  endfunction

  always @(posedge clk) bus.rom_data <= rom_val(bus.rom_addr);

  // Reference model: phase of harmonic k advances by k*step each sample.
  int unsigned mph [NH];
  int          exp_addr [NH];
  logic signed [SAMPLE_W-1:0] exp_out;
  logic signed [SAMPLE_W-1:0] last_exp;

  task automatic model_reset();
    for (int k = 0; k < NH; k++) mph[k] = 0;
  endtask

  // Predict addresses and output for the next sample, then advance phases.
  task automatic predict(input logic [STEP_W-1:0] step, input logic [NH*GAIN_W-1:0] g);
    longint s = 0;
    for (int k = 0; k < NH; k++) begin
      exp_addr[k] = int'(mph[k] >> (STEP_W - ADDR_W));
      s += longint'(rom_val(ADDR_W'(exp_addr[k]))) * longint'(int'(g[k*GAIN_W +: GAIN_W]));
    end
    s = s >>> GAIN_W;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    exp_out  = SAMPLE_W'(s);
    last_exp = exp_out;
    for (int k = 0; k < NH; k++)
      mph[k] = (mph[k] + (k + 1) * int'(step)) % (1 << STEP_W);
  endtask

  // Captured observations of the last run_sample.
  int          cap_addr [NH];
  int          ready_cnt;
  int          ready_cyc;
  logic [15:0] busy_mask;

  task automatic run_sample(input logic [STEP_W-1:0] step, input logic [NH*GAIN_W-1:0] g);
    @(negedge clk);
    bus.step_size = step;
    bus.gains = g;
    bus.generate_next_sample = 1'b1;
    @(negedge clk);
    bus.generate_next_sample = 1'b0;
    ready_cnt = 0; ready_cyc = -1; busy_mask = '0;
    for (int c = 1; c <= 2*NH + 3; c++) begin
      if (bus.busy) busy_mask[c] = 1'b1;
      if (bus.sample_ready) begin ready_cnt++; ready_cyc = c; end
      if ((c % 2 == 1) && (c <= 2*NH)) cap_addr[(c-1)/2] = int'(bus.rom_addr);
      @(negedge clk);
    end
  endtask

  task automatic pulse_note_start();
    @(negedge clk);
    bus.note_start = 1'b1;
    @(negedge clk);
    bus.note_start = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.play_enable = 1'b0; bus.generate_next_sample = 1'b0; bus.note_done = 1'b0;
    bus.note_start = 1'b0; bus.step_size = '0; bus.gains = '0;
    rom_const_mode = 1'b1; rom_const = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.sample_ready); end
    n_tests++; if (bus.harmonic_out !== 16'sd0) begin n_fail++; $display("FAIL reset_out: got %0d want 0", bus.harmonic_out); end
    n_tests++; if (bus.rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr); end
    reset = 1'b0;
    bus.play_enable = 1'b1;
  endtask

  task automatic test_latency_gain();
    rom_const_mode = 1'b1; rom_const = 16'sd1000;
    predict(20'h01234, 16'h0008);
    run_sample(20'h01234, 16'h0008);
    n_tests++; if (ready_cnt !== 1) begin n_fail++; $display("FAIL lat_ready_count: got %0d want 1", ready_cnt); end
    n_tests++; if (ready_cyc !== 9) begin n_fail++; $display("FAIL lat_ready_cycle: got %0d want 9", ready_cyc); end
    n_tests++; if (busy_mask !== 16'h03FE) begin n_fail++; $display("FAIL lat_busy_cycles: got %h want 03fe", busy_mask); end
    n_tests++; if (bus.harmonic_out !== 16'sd500) begin n_fail++; $display("FAIL lat_out: got %0d want 500", bus.harmonic_out); end
  endtask

  task automatic test_addr_seq();
    int e [3][NH] = '{'{0,0,0,0}, '{1,2,3,4}, '{2,4,6,8}};
    rom_const_mode = 1'b1; rom_const = 16'sd100;
    pulse_note_start();
    for (int t = 0; t < 3; t++) begin
      predict(20'h00400, 16'h1111);
      run_sample(20'h00400, 16'h1111);
      for (int k = 0; k < NH; k++) begin
        n_tests++;
        if (cap_addr[k] !== e[t][k]) begin
          n_fail++; $display("FAIL addr_seq t%0d h%0d: got %0d want %0d", t, k+1, cap_addr[k], e[t][k]);
        end
      end
    end
    pulse_note_start();
    for (int t = 0; t < 2; t++) begin
      predict(20'hFFC00, 16'h1111);
      run_sample(20'hFFC00, 16'h1111);
      for (int k = 0; k < NH; k++) begin
        n_tests++;
        if (cap_addr[k] !== exp_addr[k]) begin
          n_fail++; $display("FAIL addr_wrap t%0d h%0d: got %0d want %0d", t, k+1, cap_addr[k], exp_addr[k]);
        end
      end
    end
    n_tests++; if (cap_addr[0] !== 1023) begin n_fail++; $display("FAIL addr_wrap_1023: got %0d want 1023", cap_addr[0]); end
  endtask

  task automatic test_saturation();
    logic signed [SAMPLE_W-1:0] rv [3] = '{16'sd32767, -16'sd32768, -16'sd1000};
    logic [NH*GAIN_W-1:0]       gv [3] = '{16'hFFFF, 16'hFFFF, 16'h4444};
    logic signed [SAMPLE_W-1:0] ov [3] = '{16'sd32767, -16'sd32768, -16'sd1000};
    rom_const_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rom_const = rv[i];
      predict(20'h0ABCD, gv[i]);
      run_sample(20'h0ABCD, gv[i]);
      n_tests++;
      if (bus.harmonic_out !== ov[i]) begin
        n_fail++; $display("FAIL sat_%0d: got %0d want %0d", i, bus.harmonic_out, ov[i]);
      end
    end
  endtask

  task automatic test_gating();
    int seen;
    rom_const_mode = 1'b1; rom_const = 16'sd3000;
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      bus.note_done   = (m == 0);
      bus.play_enable = (m != 0) ? 1'b0 : 1'b1;
      bus.generate_next_sample = 1'b1;
      @(negedge clk);
      bus.generate_next_sample = 1'b0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        if (bus.busy || bus.sample_ready) seen++;
        @(negedge clk);
      end
      n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL gate_mode%0d: got %0d active cycles want 0", m, seen); end
      bus.note_done = 1'b0; bus.play_enable = 1'b1;
    end
    // Retrigger at cycle 3 is dropped; gating mid-sample does not abort it.
    predict(20'h02000, 16'h2468);
    @(negedge clk);
    bus.step_size = 20'h02000; bus.gains = 16'h2468; bus.generate_next_sample = 1'b1;
    @(negedge clk);
    bus.generate_next_sample = 1'b0;
    ready_cnt = 0; ready_cyc = -1;
    for (int c = 1; c <= 14; c++) begin
      if (bus.sample_ready) begin ready_cnt++; ready_cyc = c; end
      @(negedge clk);
      bus.generate_next_sample = (c == 2);
      if (c == 4) begin bus.note_done = 1'b1; bus.play_enable = 1'b0; end
    end
    bus.note_done = 1'b0; bus.play_enable = 1'b1;
    n_tests++; if (ready_cnt !== 1) begin n_fail++; $display("FAIL gate_retrigger_count: got %0d want 1", ready_cnt); end
    n_tests++; if (ready_cyc !== 9) begin n_fail++; $display("FAIL gate_retrigger_cycle: got %0d want 9", ready_cyc); end
    n_tests++; if (bus.harmonic_out !== exp_out) begin n_fail++; $display("FAIL gate_out: got %0d want %0d", bus.harmonic_out, exp_out); end
  endtask

  task automatic test_note_start();
    int busy_late;
    logic signed [SAMPLE_W-1:0] keep;
    keep = last_exp;
    rom_const_mode = 1'b1; rom_const = 16'sd2000;
    @(negedge clk);
    bus.step_size = 20'h00800; bus.gains = 16'hFFFF; bus.generate_next_sample = 1'b1;
    @(negedge clk);
    bus.generate_next_sample = 1'b0;
    ready_cnt = 0; busy_late = 0;
    for (int c = 1; c <= 12; c++) begin
      if (bus.sample_ready) ready_cnt++;
      if (c >= 5 && bus.busy) busy_late++;
      @(negedge clk);
      bus.note_start = (c == 3);
      bus.generate_next_sample = (c == 3);
    end
    model_reset();
    n_tests++; if (ready_cnt !== 0) begin n_fail++; $display("FAIL abort_ready: got %0d want 0", ready_cnt); end
    n_tests++; if (busy_late !== 0) begin n_fail++; $display("FAIL abort_busy: got %0d want 0", busy_late); end
    n_tests++; if (bus.harmonic_out !== keep) begin n_fail++; $display("FAIL abort_out: got %0d want %0d", bus.harmonic_out, keep); end
    predict(20'h00400, 16'h1111);
    run_sample(20'h00400, 16'h1111);
    for (int k = 0; k < NH; k++) begin
      n_tests++;
      if (cap_addr[k] !== 0) begin n_fail++; $display("FAIL abort_addr h%0d: got %0d want 0", k+1, cap_addr[k]); end
    end
  endtask

  task automatic test_random();
    logic [STEP_W-1:0]    st;
    logic [NH*GAIN_W-1:0] g;
    rom_const_mode = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom_tab[i] = SAMPLE_W'($urandom);
    for (int it = 0; it < 24; it++) begin
      st = STEP_W'($urandom);
      g  = (NH*GAIN_W)'($urandom);
      predict(st, g);
      run_sample(st, g);
      for (int k = 0; k < NH; k++) begin
        n_tests++;
        if (cap_addr[k] !== exp_addr[k]) begin
          n_fail++; $display("FAIL rand_addr it%0d h%0d: got %0d want %0d", it, k+1, cap_addr[k], exp_addr[k]);
        end
      end
      n_tests++;
      if (bus.harmonic_out !== exp_out) begin
        n_fail++; $display("FAIL rand_out it%0d: got %0d want %0d", it, bus.harmonic_out, exp_out);
      end
      n_tests++;
      if (ready_cnt !== 1 || ready_cyc !== 9) begin
        n_fail++; $display("FAIL rand_ready it%0d: got count %0d cycle %0d want 1 at 9", it, ready_cnt, ready_cyc);
      end
    end
  endtask

  task automatic test_async_reset();
    rom_const_mode = 1'b1; rom_const = 16'sd1000;
    predict(20'h00400, 16'h0008);
    run_sample(20'h00400, 16'h0008);
    n_tests++; if (bus.harmonic_out !== 16'sd500) begin n_fail++; $display("FAIL arst_pre_out: got %0d want 500", bus.harmonic_out); end
    @(negedge clk);
    bus.step_size = 20'h00400; bus.gains = 16'h1111; bus.generate_next_sample = 1'b1;
    @(negedge clk);
    bus.generate_next_sample = 1'b0;
    @(negedge clk);
    @(negedge clk);   // cycle 3: ADDR of harmonic 2
    #2 reset = 1'b1;
    #1;
    n_tests++; if (bus.harmonic_out !== 16'sd0) begin n_fail++; $display("FAIL arst_out: got %0d want 0", bus.harmonic_out); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.rom_addr !== '0) begin n_fail++; $display("FAIL arst_addr: got %0d want 0", bus.rom_addr); end
    n_tests++; if (bus.sample_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b want 0", bus.sample_ready); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    predict(20'h00400, 16'h1111);
    run_sample(20'h00400, 16'h1111);
    for (int k = 0; k < NH; k++) begin
      n_tests++;
      if (cap_addr[k] !== 0) begin n_fail++; $display("FAIL arst_addr_after h%0d: got %0d want 0", k+1, cap_addr[k]); end
    end
    n_tests++; if (bus.harmonic_out !== exp_out) begin n_fail++; $display("FAIL arst_out_after: got %0d want %0d", bus.harmonic_out, exp_out); end
  endtask

  initial begin
    test_reset();
    test_latency_gain();
    test_addr_seq();
    test_saturation();
    test_gating();
    test_note_start();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/harmonic_synth_engine.md
Name: harmonic_synth_engine

Overview:
- Parametrised additive-harmonic voice generator: NUM_HARM harmonics of a base note, each with its own programmable gain, summed into one signed sample per request.
- Harmonics are computed one at a time through a single shared sine ROM port, so one lookup path serves all harmonics instead of one sine reader each.
- Sits between the note player (step_size, generate_next_sample, note_done) and the voice mixer (harmonic_out, sample_ready).
- Adds over the previous generation: arbitrary harmonic count, per-harmonic gain, saturation, and a phase restart on note_start.

Parameters:
- NUM_HARM, 4: number of harmonics k = 1..NUM_HARM.
- STEP_W, 20: phase accumulator and step_size width.
- SAMPLE_W, 16: signed ROM data width and signed output width.
- GAIN_W, 4: unsigned gain width per harmonic; gain g scales by g / 2^GAIN_W.
- ADDR_W, 10: sine ROM address width (full-wave table).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- play_enable  in  1  samples are generated only when high.
- generate_next_sample  in  1  one-cycle request for the next sample.
- note_done  in  1  when high, new requests are ignored.
- note_start  in  1  one-cycle pulse: clear all phases and abort any computation in progress.
- step_size  in  STEP_W  fundamental phase increment.
- gains  in  NUM_HARM*GAIN_W  packed gains; bits [k*GAIN_W-1 -: GAIN_W] hold harmonic k.
- rom_addr  out  ADDR_W  sine ROM address.
- rom_data  in  SAMPLE_W  signed ROM output, valid one cycle after rom_addr.
- harmonic_out  out  SAMPLE_W  signed summed sample; held between updates.
- sample_ready  out  1  one-cycle pulse when harmonic_out updates.
- busy  out  1  high while a sample is being computed.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; all phase registers 0; accumulator 0; harmonic index 0.
- Trigger: generate_next_sample && play_enable && !note_done && state==IDLE.
  - At the trigger edge, step_size and gains are latched, hstep is set to step_size, acc to 0, k to 1.
  - Triggers arriving while busy are dropped. They are not queued.
- State sequence: IDLE -> ADDR -> MAC -> ADDR -> ... -> MAC -> OUT -> IDLE. There is one ADDR/MAC pair per harmonic.
- ADDR state:
  - rom_addr = phase_k[STEP_W-1 -: ADDR_W], taken from the phase value before this update. rom_addr is combinational from the phase register.
  - phase_k <= phase_k + hstep, wrapping modulo 2^STEP_W.
- MAC state:
  - acc <= acc + signed(rom_data) * unsigned(gain_k).
  - hstep <= hstep + step_latched, also wrapping modulo 2^STEP_W, so harmonic k steps by k*step_size mod 2^STEP_W.
  - k increments; after harmonic NUM_HARM the next state is OUT.
- Accumulator width is SAMPLE_W + GAIN_W + clog2(NUM_HARM) + 1, signed, and never overflows.
- OUT state:
  - harmonic_out <= saturate(acc >>> GAIN_W) to the range [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. The shift is arithmetic.
  - sample_ready = 1 for exactly this cycle.
- Latency: trigger sampled at edge 0; sample_ready is high during cycle 2*NUM_HARM+1 (cycle 9 for default parameters). busy is high from cycle 1 through the OUT cycle inclusive.
- Gain 0 makes that harmonic contribute 0, but its phase still advances.
- note_done or play_enable falling mid-computation: the current sample still completes.
- note_start, in any state, has priority over everything:
  - all phases, acc, k and hstep clear; state goes to IDLE.
  - no sample_ready for an aborted sample; harmonic_out keeps its last value.
  - a trigger in the same cycle is ignored.
- rom_addr holds its last value outside ADDR.

Test Plan:
- Latency and gain: ROM model returns constant 1000, gains={0,0,0,8} (harmonic 1 = 8), one trigger -> sample_ready high only at cycle 9, harmonic_out=500, busy high for cycles 1-9.
- Address sequence: step_size=20'h00400, all gains 1, three triggers.
  - 1st trigger: rom_addr 0,0,0,0.
  - 2nd trigger: rom_addr 1,2,3,4.
  - 3rd trigger: rom_addr 2,4,6,8.
  - With step_size=20'hFFC00, harmonic 1 wraps to address 1023 on the 2nd sample.
- Saturation:
  - ROM constant 32767, all gains 15 -> harmonic_out=32767.
  - ROM constant -32768, all gains 15 -> harmonic_out=-32768.
  - ROM constant -1000, gains all 4 -> harmonic_out=-1000.
- Gating: trigger with note_done=1 or play_enable=0 -> no busy, no sample_ready. A second trigger at cycle 3 of an active sample -> exactly one sample_ready.
- note_start at cycle 4 of a computation -> no sample_ready, harmonic_out unchanged. The next trigger uses addresses 0,0,0,0.
- Asynchronous reset asserted mid-ADDR and between clock edges -> outputs 0 immediately. After release, the first sample uses addresses 0,0,0,0.
